clk_div_prog: RTL

Parametrised successor to the fixed /2,/4,/8 clock divider. It provides two outputs:
- a free-running binary divider chain of STAGES outputs (clk/2 .. clk/2^STAGES);
- one programmable divided clock with a run-time divide ratio and high-time, plus a one-cycle period tick.

Reconfiguration is glitch-free and takes effect only at a period boundary. The block sits in the clock/timing area. It feeds enable-style strobes and slow divided clocks to downstream blocks in the same clk domain.

---
 rtl/clk_div_prog.sv | 130 +++++++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - free-running binary divider chain plus programmable divided clock with period tick
//
// Purpose:
//   chain   : STAGES-bit binary counter; chain[i] toggles at clk / 2^(i+1).
//   out_div : programmable divided clock, high for hi_act cycles out of
//             every div_act cycles.
//   tick    : one-cycle strobe on the last cycle of each out_div period.
//   A new ratio and high-time can be loaded at run time. The new values are
//   held as pending and only take effect at a period boundary, so out_div
//   never produces a runt pulse.
//
// Ports:
//   clk      in   1       system clock, all logic on posedge
//   reset    in   1       synchronous active-high reset
//   en       in   1       count enable; low freezes counters and outputs
//   load     in   1       single-cycle request to capture div_val/hi_val
//   div_val  in   W       requested divide ratio
//   hi_val   in   W       requested high-time
//   chain    out  STAGES  binary divider outputs (registered)
//   out_div  out  1       programmable divided clock (registered)
//   tick     out  1       last-cycle-of-period pulse (registered)
//   busy     out  1       a captured config is waiting for the next boundary

module clk_div_prog #(
    parameter int W           = 8,
    parameter int STAGES      = 3,
    parameter int DEFAULT_DIV = 4,
    parameter int DEFAULT_HI  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [W-1:0]      div_val,
    input  logic [W-1:0]      hi_val,
    output logic [STAGES-1:0] chain,
    output logic              out_div,
    output logic              tick,
    output logic              busy
);

    localparam logic [W-1:0] DIV_RST = W'(DEFAULT_DIV);
    localparam logic [W-1:0] HI_RST  = W'(DEFAULT_HI);
    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] TWO     = W'(2);

    // Active and pending configuration, and the position within the period.
    logic [W-1:0] pcnt;
    logic [W-1:0] div_act;
    logic [W-1:0] hi_act;
    logic [W-1:0] div_pend;
    logic [W-1:0] hi_pend;

    // Next-state values shared by the register block.
    logic [W-1:0] div_san;
    logic [W-1:0] hi_san;
    logic         wrap;
    logic         apply;
    logic [W-1:0] pcnt_nxt;
    logic [W-1:0] div_nxt;
    logic [W-1:0] hi_nxt;
    logic         out_nxt;
    logic         tick_nxt;

    always_comb begin
        // Clamp requested values into a legal pair: at least a 2-cycle period,
        // at least one high cycle and at least one low cycle.
        div_san = div_val;
        if (div_val < TWO) begin
            div_san = TWO;
        end
        hi_san = hi_val;
        if (hi_val == '0) begin
            hi_san = ONE;
        end else if (hi_val >= div_san) begin
            hi_san = div_san - ONE;
        end

        wrap  = (pcnt == div_act - ONE);
        // busy only reflects captures from earlier edges, so a load arriving
        // on this very edge is never applied here.
        apply = en && wrap && busy;

        pcnt_nxt = wrap ? '0 : pcnt + ONE;
        div_nxt  = apply ? div_pend : div_act;
        hi_nxt   = apply ? hi_pend  : hi_act;

        // Outputs are registered from the values pcnt/config will hold after
        // this edge, so out_div and tick line up with the stored pcnt.
        out_nxt  = (pcnt_nxt < hi_nxt);
        tick_nxt = (pcnt_nxt == div_nxt - ONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain    <= '0;
            pcnt     <= DIV_RST - ONE;
            div_act  <= DIV_RST;
            hi_act   <= HI_RST;
            div_pend <= DIV_RST;
            hi_pend  <= HI_RST;
            busy     <= 1'b0;
            out_div  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            if (en) begin
                chain   <= chain + STAGES'(1);
                pcnt    <= pcnt_nxt;
                div_act <= div_nxt;
                hi_act  <= hi_nxt;
                out_div <= out_nxt;
                tick    <= tick_nxt;
            end else begin
                tick    <= 1'b0;
            end

            // Capture is independent of en. A capture coinciding with an
            // apply replaces the pending slot after its old contents were
            // consumed above, so busy stays set.
            if (load) begin
                div_pend <= div_san;
                hi_pend  <= hi_san;
                busy     <= 1'b1;
            end else if (apply) begin
                busy     <= 1'b0;
            end
        end
    end

endmodule
